id_stage_pipe: RTL
==================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter DATA_W, 32, register-file and operand data width.
REQ-002 Parameter REG_ADDR_W, 4, register index width; register file holds 2**REG_ADDR_W entries.
REQ-003 Parameter PC_W, 32, program-counter width carried through the stage.
REQ-004 Ports: clk in 1 clock; rst in 1 reset, synchronous, active-low; only one clock in the block.
REQ-005 in_valid in 1 instruction present; in_ready out 1 instruction accepted when in_valid&&in_ready.
REQ-006 instruction in 32 ARM-format word; pc in PC_W address of the instruction; status in 4 flags {N,Z,C,V}.
REQ-007 flush in 1 taken-branch kill of the stage.
REQ-008 wb_en in 1, wb_dest in REG_ADDR_W, wb_data in DATA_W: register-file write port.
REQ-009 exe_wb_en in 1, exe_dest in REG_ADDR_W, mem_wb_en in 1, mem_dest in REG_ADDR_W: downstream pending writers.
REQ-010 out_valid out 1, out_ready in 1: output handshake, transfer when both high.
REQ-011 Registered outputs: out_exec_cmd 4, out_mem_read 1, out_mem_write 1, out_wb_en 1, out_branch 1, out_s 1, out_imm 1.
REQ-012 Registered outputs: out_reg1/out_reg2 DATA_W, out_shift_operand 12, out_signed_imm 24, out_dest/out_src1/out_src2 REG_ADDR_W, out_pc PC_W.
REQ-013 hazard out 1 combinational data-hazard indication.

Function
REQ-014 Control decode uses the team's existing ControlUnit opcode/mode/S mapping and ConditionCheck condition mapping, unchanged.
REQ-015 Fields: src1=instr[19:16]; dest=instr[15:12]; src2=dest when decoded memWrite, else instr[3:0]; imm=instr[25]; shift=instr[11:0]; simm=instr[23:0].
REQ-016 src1 used unless mode=00 with opcode MOV(1101) or MVN(1111); src2 used when memWrite, or mode=00 with imm=0.
REQ-017 hazard=in_valid && used src matches exe_dest with exe_wb_en=1, or mem_dest with mem_wb_en=1; upper index bits beyond REG_ADDR_W ignored.
REQ-018 in_ready=!hazard && !flush && (!out_valid || out_ready).
REQ-019 Latency: accepted instruction appears on outputs with out_valid=1 on the next clk edge.
REQ-020 Condition fail on accepted instruction: out_valid=1, out_exec_cmd/out_mem_read/out_mem_write/out_wb_en/out_branch/out_s all 0; data fields still loaded.
REQ-021 Stall: out_valid=1 && out_ready=0 and no flush -> every output register holds value.
REQ-022 Bubble: no acceptance and (out_ready=1 or out_valid=0) -> out_valid cleared next edge, other output registers may hold.
REQ-023 flush=1 -> out_valid=0 next edge regardless of out_ready, hazard or in_valid; flush has highest priority after reset.
REQ-024 Register file: write at clk edge when wb_en=1; writes never blocked by stall, hazard or flush.
REQ-025 Read bypass: read index equal to wb_dest with wb_en=1 returns wb_data in the same cycle.
REQ-026 Operand width: register data DATA_W, no sign extension or truncation inside the block.

Reset
REQ-027 rst=0 at a clk edge -> out_valid=0, all output registers 0, all register-file entries 0.
REQ-028 While rst=0, in_ready=0 and register-file writes ignored; reset mid-stall discards held instruction.
REQ-029 First acceptance possible on the first edge with rst=1.

Verification
REQ-030 Write R3=0x0000_00AA via wb port, then ADD R4,R3,R2 (cond AL) with R2=0x10 -> next cycle out_reg1=0xAA, out_reg2=0x10, out_valid=1, out_dest=4.
REQ-031 exe_wb_en=1, exe_dest=3, instruction reads R3 -> hazard=1, in_ready=0, out_valid=0 next edge; drop exe_wb_en -> accepted next cycle.
REQ-032 Condition EQ with status Z=0 -> out_valid=1, all control outputs 0, out_dest=instr[15:12].
REQ-033 out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0; out_ready=1 -> next instruction loaded one edge later.
REQ-034 flush=1 during stall and in_valid=1 -> out_valid=0 next edge, instruction not accepted; wb write same cycle still lands.
REQ-035 wb_en=1, wb_dest=5, wb_data=0x1234 same cycle as STR reading R5 as src2 -> out_reg2=0x1234; rst=0 afterward clears R5 to 0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode pipeline stage. It decodes an ARM-format
// word, reads two operands from a bypassed register file, flags data hazards
// against downstream writers, and hands the decoded bundle to execute through
// a valid/ready output register that is cleared by a taken-branch flush.
module id_stage_pipe #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4,
   parameter int PC_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instruction,
   input  logic [PC_W-1:0]       pc,
   input  logic [3:0]            status,
   input  logic                  flush,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  exe_wb_en,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  mem_wb_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0]            out_exec_cmd,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_wb_en,
   output logic                  out_branch,
   output logic                  out_s,
   output logic                  out_imm,
   output logic [DATA_W-1:0]     out_reg1,
   output logic [DATA_W-1:0]     out_reg2,
   output logic [11:0]           out_shift_operand,
   output logic [23:0]           out_signed_imm,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic [REG_ADDR_W-1:0] out_src1,
   output logic [REG_ADDR_W-1:0] out_src2,
   output logic [PC_W-1:0]       out_pc,
   output logic                  hazard
);

   localparam int NREG = 1 << REG_ADDR_W;

   // Condition field evaluated against the {N,Z,C,V} flags.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v, r;
      n = flags[3];
      z = flags[2];
      c = flags[1];
      v = flags[0];
      case (cond)
         4'b0000: r = z;
         4'b0001: r = !z;
         4'b0010: r = c;
         4'b0011: r = !c;
         4'b0100: r = n;
         4'b0101: r = !n;
         4'b0110: r = v;
         4'b0111: r = !v;
         4'b1000: r = c && !z;
         4'b1001: r = !c || z;
         4'b1010: r = (n == v);
         4'b1011: r = (n != v);
         4'b1100: r = !z && (n == v);
         4'b1101: r = z || (n != v);
         4'b1110: r = 1'b1;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   logic [DATA_W-1:0]     r_rf [NREG];
   logic                  r_out_valid;
   logic [3:0]            r_exec_cmd;
   logic                  r_mem_read, r_mem_write, r_wb_en, r_branch, r_s, r_imm;
   logic [DATA_W-1:0]     r_reg1, r_reg2;
   logic [11:0]           r_shift;
   logic [23:0]           r_simm;
   logic [REG_ADDR_W-1:0] r_dest, r_src1, r_src2;
   logic [PC_W-1:0]       r_pc;

   logic [1:0]            w_mode;
   logic [3:0]            w_opcode;
   logic                  w_s_bit, w_imm_bit, w_cond_ok;
   logic [3:0]            w_exec_cmd;
   logic                  w_mem_read, w_mem_write, w_wb_en, w_branch, w_s;
   logic [REG_ADDR_W-1:0] w_src1, w_src2, w_dest;
   logic                  w_use1, w_use2, w_hazard, w_in_ready, w_accept;
   logic [DATA_W-1:0]     w_reg1, w_reg2;

   assign w_mode    = instruction[27:26];
   assign w_imm_bit = instruction[25];
   assign w_opcode  = instruction[24:21];
   assign w_s_bit   = instruction[20];
   assign w_cond_ok = cond_pass(instruction[31:28], status);

   // Control decode from mode/opcode/S.
   always_comb begin
      w_exec_cmd  = 4'b0000;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_wb_en     = 1'b0;
      w_branch    = 1'b0;
      w_s         = 1'b0;
      case (w_mode)
         2'b00: begin
            w_s = w_s_bit;
            case (w_opcode)
               4'b1101: begin w_exec_cmd = 4'b0001; w_wb_en = 1'b1; end // MOV
               4'b1111: begin w_exec_cmd = 4'b1001; w_wb_en = 1'b1; end // MVN
               4'b0100: begin w_exec_cmd = 4'b0010; w_wb_en = 1'b1; end // ADD
               4'b0101: begin w_exec_cmd = 4'b0011; w_wb_en = 1'b1; end // ADC
               4'b0010: begin w_exec_cmd = 4'b0100; w_wb_en = 1'b1; end // SUB
               4'b0110: begin w_exec_cmd = 4'b0101; w_wb_en = 1'b1; end // SBC
               4'b0000: begin w_exec_cmd = 4'b0110; w_wb_en = 1'b1; end // AND
               4'b1100: begin w_exec_cmd = 4'b0111; w_wb_en = 1'b1; end // ORR
               4'b0001: begin w_exec_cmd = 4'b1000; w_wb_en = 1'b1; end // EOR
               4'b1010: w_exec_cmd = 4'b0100;                            // CMP
               4'b1000: w_exec_cmd = 4'b0110;                            // TST
               default: w_exec_cmd = 4'b0000;
            endcase
         end
         2'b01: begin
            w_exec_cmd = 4'b0010;
            if (w_s_bit) begin
               w_mem_read = 1'b1;
               w_wb_en    = 1'b1;
            end else begin
               w_mem_write = 1'b1;
            end
         end
         2'b10:   w_branch = 1'b1;
         default: w_branch = 1'b0;
      endcase
   end

   // Stores read the data register through the second port.
   assign w_src1 = instruction[16 +: REG_ADDR_W];
   assign w_dest = instruction[12 +: REG_ADDR_W];
   assign w_src2 = w_mem_write ? instruction[12 +: REG_ADDR_W] : instruction[0 +: REG_ADDR_W];

   assign w_use1 = !((w_mode == 2'b00) && ((w_opcode == 4'b1101) || (w_opcode == 4'b1111)));
   assign w_use2 = w_mem_write || ((w_mode == 2'b00) && !w_imm_bit);

   assign w_hazard = in_valid &&
      ((w_use1 && ((exe_wb_en && (exe_dest == w_src1)) || (mem_wb_en && (mem_dest == w_src1)))) ||
       (w_use2 && ((exe_wb_en && (exe_dest == w_src2)) || (mem_wb_en && (mem_dest == w_src2)))));

   assign w_in_ready = rst && !w_hazard && !flush && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;

   // Same-cycle write-back is forwarded so a reader never sees stale data.
   assign w_reg1 = (wb_en && (wb_dest == w_src1)) ? wb_data : r_rf[w_src1];
   assign w_reg2 = (wb_en && (wb_dest == w_src2)) ? wb_data : r_rf[w_src2];

   // Register file: cleared in reset, otherwise written whenever wb_en is set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (wb_en) begin
         r_rf[wb_dest] <= wb_data;
      end
   end

   // Output register: reset, flush, load, bubble or hold under back-pressure.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_exec_cmd  <= 4'b0000;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_wb_en     <= 1'b0;
         r_branch    <= 1'b0;
         r_s         <= 1'b0;
         r_imm       <= 1'b0;
         r_reg1      <= '0;
         r_reg2      <= '0;
         r_shift     <= 12'd0;
         r_simm      <= 24'd0;
         r_dest      <= '0;
         r_src1      <= '0;
         r_src2      <= '0;
         r_pc        <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_exec_cmd  <= w_cond_ok ? w_exec_cmd : 4'b0000;
         r_mem_read  <= w_cond_ok && w_mem_read;
         r_mem_write <= w_cond_ok && w_mem_write;
         r_wb_en     <= w_cond_ok && w_wb_en;
         r_branch    <= w_cond_ok && w_branch;
         r_s         <= w_cond_ok && w_s;
         r_imm       <= w_imm_bit;
         r_reg1      <= w_reg1;
         r_reg2      <= w_reg2;
         r_shift     <= instruction[11:0];
         r_simm      <= instruction[23:0];
         r_dest      <= w_dest;
         r_src1      <= w_src1;
         r_src2      <= w_src2;
         r_pc        <= pc;
      end else if (out_ready || !r_out_valid) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

   assign in_ready          = w_in_ready;
   assign hazard            = w_hazard;
   assign out_valid         = r_out_valid;
   assign out_exec_cmd      = r_exec_cmd;
   assign out_mem_read      = r_mem_read;
   assign out_mem_write     = r_mem_write;
   assign out_wb_en         = r_wb_en;
   assign out_branch        = r_branch;
   assign out_s             = r_s;
   assign out_imm           = r_imm;
   assign out_reg1          = r_reg1;
   assign out_reg2          = r_reg2;
   assign out_shift_operand = r_shift;
   assign out_signed_imm    = r_simm;
   assign out_dest          = r_dest;
   assign out_src1          = r_src1;
   assign out_src2          = r_src2;
   assign out_pc            = r_pc;

endmodule
